// File: rtl/sccb_reg_sequencer.sv
// SCCB register-table sequencer: walks a {addr, value} table held in an
// external ROM and hands each write to the SCCB master. It waits for the
// master's completion pulse, retries NACKed writes up to MAX_RETRY times and
// treats entries whose address is DELAY_ADDR as a timed pause.
//
// Handshake: data/data_valid are driven from registers and held stable until
// the cycle where data_valid && data_ready are both high at a rising clk edge;
// that edge is the transfer, and data_valid is low from the next cycle on.
// wr_done/wr_err are only looked at while waiting for the completion of an
// accepted write. A start pulse restarts from index 0 and wins over any other
// same-cycle event.
`timescale 1ns/1ps
module sccb_reg_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                NUM_REGS   = 64,
  parameter logic [ADDR_W-1:0] DELAY_ADDR = 8'hFF,
  parameter int                DELAY_UNIT = 50000,
  parameter int                MAX_RETRY  = 3,
  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
  output logic [ADDR_W+DATA_W-1:0] data,
  output logic                     data_valid,
  input  logic                     data_ready,
  input  logic                     wr_done,
  input  logic                     wr_err,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         err_index,
  output logic [3:0]               state_dbg
);

  // Delay counter must hold (2^DATA_W-1)*DELAY_UNIT-1.
  localparam int CNT_RAW = $clog2((2 ** DATA_W - 1) * DELAY_UNIT + 1);
  localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
  localparam int RTY_RAW = $clog2(MAX_RETRY + 1);
  localparam int RTY_W   = (RTY_RAW > 0) ? RTY_RAW : 1;
  localparam int ENT_W   = ADDR_W + DATA_W;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_LATCH   = 4'd2,
    S_ISSUE   = 4'd3,
    S_WAIT    = 4'd4,
    S_DELAY   = 4'd5,
    S_ADVANCE = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;

  logic [ADDR_W-1:0]  ent_addr;
  logic [DATA_W-1:0]  ent_value;

  assign ent_addr  = rom_data[ENT_W-1:DATA_W];
  assign ent_value = rom_data[DATA_W-1:0];

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      retry_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_index_q <= err_index_d;
    end
  end

  // Next-state logic; start is applied last so it overrides every other event.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_index_d = err_index_q;
    case (state_q)
      S_IDLE: ;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (ent_addr == DELAY_ADDR) begin
          state_d = S_DELAY;
          // A zero delay still spends exactly one cycle in DELAY.
          if (ent_value == '0) cnt_d = '0;
          else cnt_d = CNT_W'(ent_value) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
        end else begin
          state_d = S_ISSUE;
          data_d  = rom_data;
        end
      end
      S_ISSUE: if (data_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (wr_done) begin
          if (!wr_err) begin
            state_d = S_ADVANCE;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_ISSUE;
          end else begin
            err_index_d = index_q;
            state_d     = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) state_d = S_ADVANCE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_ADVANCE: begin
        retry_d = '0;
        if (index_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE, S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d     = S_FETCH;
      index_d     = '0;
      retry_d     = '0;
      cnt_d       = '0;
      err_index_d = '0;
    end
  end

  assign rom_addr   = index_q;
  assign data       = data_q;
  assign data_valid = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign err_index  = err_index_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Directed bench for sccb_reg_sequencer with a 4-entry table model, an SCCB
// master responder and an expected-write queue.
`timescale 1ns/1ps
module tb_sccb_reg_sequencer;

  localparam int IDX_W = 2;
  localparam int ENT_W = 16;
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LATCH = 4'd2;
  localparam logic [3:0] ST_WAIT  = 4'd4;
  localparam logic [3:0] ST_DELAY = 4'd5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [IDX_W-1:0] rom_addr;
  logic [ENT_W-1:0] rom_q;
  logic [ENT_W-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic             wr_done;
  logic             wr_err;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_index;
  logic [3:0]       state_dbg;

  logic [ENT_W-1:0] rom [4];
  logic [ENT_W-1:0] exp_q [$];
  int               nack_left [4];
  int               resp_delay = 2;
  int               checks = 0;
  int               failures = 0;

  sccb_reg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .NUM_REGS(4), .DELAY_ADDR(8'hFF),
    .DELAY_UNIT(10), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_q), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .wr_done(wr_done), .wr_err(wr_err),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Table ROM with one cycle of read latency.
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_table(input logic [ENT_W-1:0] e0, e1, e2, e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    for (int i = 0; i < 4; i++) nack_left[i] = 0;
  endtask

  task automatic push4(input logic [ENT_W-1:0] e0, e1, e2, e3);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (state_dbg !== s && n < 2000);
    check({tag, "_reached"}, 32'(state_dbg), 32'(s));
  endtask

  // Waits for the sequence to end; reports busy from the sample before.
  task automatic wait_end(input string tag, output logic prev_busy);
    int n = 0;
    prev_busy = busy;
    @(negedge clk);
    while (!(done || error) && n < 3000) begin
      prev_busy = busy;
      @(negedge clk);
      n++;
    end
    check({tag, "_ended"}, 32'(done | error), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_flags"}, {28'd0, data_valid, busy, done, error}, 32'd0);
    check({tag, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  // SCCB master model: records each transfer against the expected queue and
  // answers with wr_done resp_delay cycles later, NACKing per nack_left.
  initial begin
    logic nack;
    int   idx;
    wr_done = 1'b0;
    wr_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && data_valid && data_ready) begin
        idx = int'(rom_addr);
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_data", 32'(data), 32'(exp_q.pop_front()));
        nack = (nack_left[idx] > 0);
        if (nack) nack_left[idx]--;
        @(posedge clk);
        repeat (resp_delay - 1) @(posedge clk);
        #1 wr_done = 1'b1; wr_err = nack;
        @(posedge clk);
        #1 wr_done = 1'b0; wr_err = 1'b0;
      end
    end
  end

  initial begin
    logic pb;
    int   n;
    int   dcyc;
    reset_n    = 1'b0;
    start      = 1'b0;
    data_ready = 1'b1;
    load_table(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);

    // Reset state.
    #17;
    check_all_zero("reset");
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1 reset_n = 1'b1;

    // Plain four-write sequence with start-to-valid latency.
    push4(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
    pulse_start();
    n = 0;
    while (!data_valid && n < 50) begin @(negedge clk); n++; end
    check("t1_first_valid_latency", 32'(n), 32'd3);
    wait_end("t1", pb);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_fall", {30'd0, pb, busy}, 32'b10);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // data_ready held low for 10 cycles.
    data_ready = 1'b0;
    push4(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
    pulse_start();
    n = 0;
    while (!data_valid && n < 50) begin @(negedge clk); n++; end
    check("t5_valid_seen", 32'(data_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold", {15'd0, data_valid, data}, {15'd0, 1'b1, 16'h1280});
      @(negedge clk);
    end
    @(posedge clk); #1 data_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_xfer_first_ready", {27'd0, data_valid, state_dbg}, {27'd0, 1'b0, ST_WAIT});
    wait_end("t5", pb);
    check("t5_done", 32'(done), 32'd1);

    // Delay entry {FF,02} with DELAY_UNIT=10.
    load_table(16'h1280, 16'hFF02, 16'h3A04, 16'h40D0);
    exp_q.push_back(16'h1280); exp_q.push_back(16'h3A04); exp_q.push_back(16'h40D0);
    pulse_start();
    wait_state(ST_DELAY, "t2_delay");
    n = 0;
    dcyc = 1;
    while (!data_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (state_dbg == ST_DELAY) dcyc++;
    end
    check("t2_delay_cycles", 32'(dcyc), 32'd20);
    check("t2_delay_to_valid", 32'(n), 32'd23);
    wait_end("t2", pb);
    check("t2_done", 32'(done), 32'd1);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Entry 1 NACKed three times, then accepted.
    load_table(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
    nack_left[1] = 3;
    exp_q.push_back(16'h1280);
    repeat (4) exp_q.push_back(16'h1101);
    exp_q.push_back(16'h3A04); exp_q.push_back(16'h40D0);
    pulse_start();
    wait_end("t3", pb);
    check("t3_done_error", {30'd0, done, error}, 32'b10);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Entry 2 NACKed four times: retries exhausted.
    nack_left[2] = 4;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
    repeat (4) exp_q.push_back(16'h3A04);
    pulse_start();
    wait_end("t4", pb);
    check("t4_flags", {29'd0, busy, done, error}, 32'b001);
    check("t4_err_index", 32'(err_index), 32'd2);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    nack_left[2] = 0;
    push4(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
    pulse_start();
    @(negedge clk);
    check("t4_restart", {28'd0, error, busy, rom_addr}, {28'd0, 1'b0, 1'b1, 2'd0});
    wait_end("t4b", pb);
    check("t4b_done", {30'd0, done, error}, 32'b10);

    // start during WAIT at index 2, stale wr_done arrives a cycle later.
    resp_delay = 3;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1101); exp_q.push_back(16'h3A04);
    push4(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(state_dbg == ST_WAIT && rom_addr == 2'd2) && n < 2000);
    check("t6_wait_idx2", {28'd0, state_dbg}, {28'd0, ST_WAIT});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    resp_delay = 2;
    @(negedge clk);
    check("t6_abort", {25'd0, state_dbg, data_valid, busy, rom_addr},
          {25'd0, ST_FETCH, 1'b0, 1'b1, 2'd0});
    @(negedge clk);
    check("t6_stale_ignored", 32'(state_dbg), 32'(ST_LATCH));
    wait_end("t6", pb);
    check("t6_done", {30'd0, done, error}, 32'b10);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted in the middle of a delay.
    load_table(16'h1280, 16'hFF05, 16'h3A04, 16'h40D0);
    exp_q.push_back(16'h1280);
    pulse_start();
    wait_state(ST_DELAY, "t6r_delay");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("t6r");
    check("t6r_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6r_stays_idle", {27'd0, state_dbg, busy}, {27'd0, ST_IDLE, 1'b0});
    check("t6r_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
